// File: rtl/sd_ctrl.sv
// sd_ctrl: SPI bus controller/arbiter for the SD card interface.
// The initialiser owns the card bus until init_end. After that the bus is
// shared between the block-write and block-read engines. Pulse requests are
// latched, arbitrated with alternating priority and turned into one-cycle
// start strobes. Engine busy handshakes are supervised by a timeout counter.
//
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   init_end/init_cs_n/mosi     initialiser done level and its bus signals
//   wr_req/wr_addr              write request pulse and block address
//   rd_req/rd_addr              read request pulse and block address
//   wr_busy/wr_cs_n/wr_mosi     write engine handshake and bus signals
//   rd_busy/rd_cs_n/rd_mosi     read engine handshake and bus signals
//   cs_n, mosi                  card bus (muxed from the current owner)
//   wr_en, rd_en                one-cycle engine start strobes
//   blk_addr                    address of the granted operation
//   wr_done, rd_done            one-cycle completion pulses
//   ctrl_busy                   high unless idle with nothing pending
//   ctrl_err                    sticky timeout flag
module sd_ctrl #(
  parameter logic [15:0] START_TO = 16'd1000,
  parameter logic [23:0] OP_TO    = 24'd2_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        init_cs_n,
  input  logic        init_mosi,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        wr_busy,
  input  logic        wr_cs_n,
  input  logic        wr_mosi,
  input  logic        rd_busy,
  input  logic        rd_cs_n,
  input  logic        rd_mosi,
  output logic        cs_n,
  output logic        mosi,
  output logic        wr_en,
  output logic        rd_en,
  output logic [31:0] blk_addr,
  output logic        wr_done,
  output logic        rd_done,
  output logic        ctrl_busy,
  output logic        ctrl_err
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_WR_START = 3'd2,
    S_WR       = 3'd3,
    S_RD_START = 3'd4,
    S_RD       = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic        wr_pend_r, wr_pend_s, rd_pend_r, rd_pend_s;
  logic [31:0] wr_addr_r, rd_addr_r;
  logic        wr_cap_s, rd_cap_s;
  logic        prio_rd_r, prio_rd_s;       // 0: write wins a tie, 1: read wins
  logic [23:0] timer_r;
  logic        grant_wr_s, grant_rd_s;
  logic        set_err_s, wr_done_s, rd_done_s;
  logic        start_exp_s, op_exp_s;
  logic        wr_en_r, rd_en_r, wr_done_r, rd_done_r, ctrl_busy_r, ctrl_err_r;
  logic [31:0] blk_addr_r;

  // Expiry compares are done one bit wider so a saturated timer cannot wrap.
  assign start_exp_s = ({1'b0, timer_r} + 25'd1) >= {9'd0, START_TO};
  assign op_exp_s    = ({1'b0, timer_r} + 25'd1) >= {1'b0, OP_TO};

  // Next-state, grant and pending-flag logic.
  always_comb begin
    state_s    = state_r;
    prio_rd_s  = prio_rd_r;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    set_err_s  = 1'b0;
    wr_done_s  = 1'b0;
    rd_done_s  = 1'b0;
    case (state_r)
      S_INIT: begin
        if (init_end) state_s = S_IDLE;
        else          state_s = S_INIT;
      end
      S_IDLE: begin
        if (wr_pend_r && rd_pend_r) begin
          if (prio_rd_r) begin
            grant_rd_s = 1'b1;
            prio_rd_s  = 1'b0;
            state_s    = S_RD_START;
          end else begin
            grant_wr_s = 1'b1;
            prio_rd_s  = 1'b1;
            state_s    = S_WR_START;
          end
        end else if (wr_pend_r) begin
          grant_wr_s = 1'b1;
          state_s    = S_WR_START;
        end else if (rd_pend_r) begin
          grant_rd_s = 1'b1;
          state_s    = S_RD_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_START: begin
        if (wr_busy) state_s = S_WR;
        else if (start_exp_s) begin
          set_err_s = 1'b1;
          state_s   = S_IDLE;
        end else state_s = S_WR_START;
      end
      S_WR: begin
        if (!wr_busy) begin
          wr_done_s = 1'b1;
          state_s   = S_IDLE;
        end else if (op_exp_s) begin
          set_err_s = 1'b1;
          state_s   = S_IDLE;
        end else state_s = S_WR;
      end
      S_RD_START: begin
        if (rd_busy) state_s = S_RD;
        else if (start_exp_s) begin
          set_err_s = 1'b1;
          state_s   = S_IDLE;
        end else state_s = S_RD_START;
      end
      S_RD: begin
        if (!rd_busy) begin
          rd_done_s = 1'b1;
          state_s   = S_IDLE;
        end else if (op_exp_s) begin
          set_err_s = 1'b1;
          state_s   = S_IDLE;
        end else state_s = S_RD;
      end
      default: state_s = S_INIT;
    endcase

    // A request is accepted when nothing is pending, or when the pending one
    // is being granted this very cycle (so it is not lost).
    wr_cap_s = wr_req && (!wr_pend_r || grant_wr_s);
    rd_cap_s = rd_req && (!rd_pend_r || grant_rd_s);
    if (wr_cap_s)        wr_pend_s = 1'b1;
    else if (grant_wr_s) wr_pend_s = 1'b0;
    else                 wr_pend_s = wr_pend_r;
    if (rd_cap_s)        rd_pend_s = 1'b1;
    else if (grant_rd_s) rd_pend_s = 1'b0;
    else                 rd_pend_s = rd_pend_r;
  end

  // Card bus mux, driven by the owner implied by the registered state.
  always_comb begin
    cs_n = 1'b1;
    mosi = 1'b1;
    case (state_r)
      S_INIT: begin
        cs_n = init_cs_n;
        mosi = init_mosi;
      end
      S_WR_START, S_WR: begin
        cs_n = wr_cs_n;
        mosi = wr_mosi;
      end
      S_RD_START, S_RD: begin
        cs_n = rd_cs_n;
        mosi = rd_mosi;
      end
      default: begin
        cs_n = 1'b1;
        mosi = 1'b1;
      end
    endcase
  end

  // State, request latches, timeout counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= S_INIT;
      wr_pend_r   <= 1'b0;
      rd_pend_r   <= 1'b0;
      wr_addr_r   <= 32'd0;
      rd_addr_r   <= 32'd0;
      prio_rd_r   <= 1'b0;
      timer_r     <= 24'd0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      blk_addr_r  <= 32'd0;
      wr_done_r   <= 1'b0;
      rd_done_r   <= 1'b0;
      ctrl_busy_r <= 1'b1;
      ctrl_err_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      wr_pend_r <= wr_pend_s;
      rd_pend_r <= rd_pend_s;
      prio_rd_r <= prio_rd_s;
      if (wr_cap_s) wr_addr_r <= wr_addr;
      if (rd_cap_s) rd_addr_r <= rd_addr;
      if (state_s != state_r)      timer_r <= 24'd0;
      else if (timer_r != 24'hFF_FFFF) timer_r <= timer_r + 24'd1;
      // Strobes are set on the grant edge so they coincide with the
      // first *_START cycle.
      wr_en_r <= grant_wr_s;
      rd_en_r <= grant_rd_s;
      if (grant_wr_s)      blk_addr_r <= wr_addr_r;
      else if (grant_rd_s) blk_addr_r <= rd_addr_r;
      wr_done_r   <= wr_done_s;
      rd_done_r   <= rd_done_s;
      ctrl_busy_r <= !((state_s == S_IDLE) && !wr_pend_s && !rd_pend_s);
      ctrl_err_r  <= ctrl_err_r | set_err_s;
    end
  end

  assign wr_en     = wr_en_r;
  assign rd_en     = rd_en_r;
  assign blk_addr  = blk_addr_r;
  assign wr_done   = wr_done_r;
  assign rd_done   = rd_done_r;
  assign ctrl_busy = ctrl_busy_r;
  assign ctrl_err  = ctrl_err_r;

endmodule

// File: tb/tb_sd_ctrl.sv
// tb_sd_ctrl: directed bench for sd_ctrl. Expected grants (side + address)
// are pushed to a scoreboard queue when requests are driven and popped by a
// monitor whenever a start strobe appears.
module tb_sd_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst, init_end, init_cs_n, init_mosi;
  logic        wr_req, rd_req, wr_busy, wr_cs_n, wr_mosi, rd_busy, rd_cs_n, rd_mosi;
  logic [31:0] wr_addr, rd_addr, blk_addr;
  logic        cs_n, mosi, wr_en, rd_en, wr_done, rd_done, ctrl_busy, ctrl_err;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  localparam logic [31:0] DUP_A = 32'hD00D_0001;
  localparam logic [31:0] DUP_B = 32'hBAD0_0002;

  sd_ctrl #(.START_TO(16'd10), .OP_TO(24'd700)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cs_n(init_cs_n), .init_mosi(init_mosi),
    .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_busy(wr_busy), .wr_cs_n(wr_cs_n), .wr_mosi(wr_mosi),
    .rd_busy(rd_busy), .rd_cs_n(rd_cs_n), .rd_mosi(rd_mosi),
    .cs_n(cs_n), .mosi(mosi), .wr_en(wr_en), .rd_en(rd_en),
    .blk_addr(blk_addr), .wr_done(wr_done), .rd_done(rd_done),
    .ctrl_busy(ctrl_busy), .ctrl_err(ctrl_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected grant.
  always @(negedge sys_clk) begin
    if (wr_en === 1'b1 || rd_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, wr_en, rd_en}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("grant_side", {30'd0, wr_en, rd_en}, e.is_rd ? 32'd1 : 32'd2);
        check("grant_addr", blk_addr, e.addr);
      end
    end
  end

  task automatic req(input bit is_rd, input logic [31:0] a);
    @(negedge sys_clk);
    if (is_rd) begin rd_req = 1'b1; rd_addr = a; end
    else       begin wr_req = 1'b1; wr_addr = a; end
    sb.push_back('{is_rd, a});
    @(negedge sys_clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic req_pair(input logic [31:0] wa, input logic [31:0] ra, input bit rd_first);
    @(negedge sys_clk);
    wr_req = 1'b1; wr_addr = wa;
    rd_req = 1'b1; rd_addr = ra;
    if (rd_first) begin sb.push_back('{1'b1, ra}); sb.push_back('{1'b0, wa}); end
    else          begin sb.push_back('{1'b0, wa}); sb.push_back('{1'b1, ra}); end
    @(negedge sys_clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Looks at the current cycle first, then waits a bounded number of cycles.
  task automatic wait_strobe(input bit is_rd, output bit seen);
    seen = is_rd ? rd_en : wr_en;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge sys_clk);
      seen = is_rd ? rd_en : wr_en;
    end
    check("strobe_seen", {31'd0, seen}, 32'd1);
  endtask

  // Emulates an engine: raise busy lat cycles after the strobe, hold it,
  // drive the bus, then expect a single done pulse.
  task automatic serve(input bit is_rd, input int lat, input int hold, input bit inject);
    bit seen;
    wait_strobe(is_rd, seen);
    if (seen) begin
      repeat (lat) @(negedge sys_clk);
      if (is_rd) rd_busy = 1'b1; else wr_busy = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge sys_clk);
        rd_cs_n = is_rd ? i[0] : ~i[0];
        rd_mosi = is_rd ? ~i[0] : i[0];
        wr_cs_n = ~rd_cs_n;
        wr_mosi = ~rd_mosi;
        if (inject && i == 100) begin wr_req = 1'b1; wr_addr = DUP_A; sb.push_back('{1'b0, DUP_A}); end
        if (inject && i == 200) begin wr_req = 1'b1; wr_addr = DUP_B; end
        if (inject && (i == 101 || i == 201)) wr_req = 1'b0;
        #1;
        if (i % 50 == 1) begin
          check("bus_cs_n", {31'd0, cs_n}, {31'd0, is_rd ? rd_cs_n : wr_cs_n});
          check("bus_mosi", {31'd0, mosi}, {31'd0, is_rd ? rd_mosi : wr_mosi});
          check("busy_in_op", {31'd0, ctrl_busy}, 32'd1);
        end
      end
      wr_busy = 1'b0; rd_busy = 1'b0;
      wr_cs_n = 1'b1; rd_cs_n = 1'b1; wr_mosi = 1'b1; rd_mosi = 1'b1;
      @(negedge sys_clk);
      check("done_pulse", {30'd0, wr_done, rd_done}, is_rd ? 32'd1 : 32'd2);
      @(negedge sys_clk);
      check("done_once", {30'd0, wr_done, rd_done}, 32'd0);
    end
  endtask

  initial begin
    bit seen;
    sys_rst = 1'b1; init_end = 1'b0; init_cs_n = 1'b0; init_mosi = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = 32'd0; rd_addr = 32'd0;
    wr_busy = 1'b0; rd_busy = 1'b0;
    wr_cs_n = 1'b1; wr_mosi = 1'b1; rd_cs_n = 1'b1; rd_mosi = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Reset values.
    check("rst_cs_n", {31'd0, cs_n}, 32'd0);
    check("rst_strobes", {28'd0, wr_en, rd_en, wr_done, rd_done}, 32'd0);
    check("rst_err", {31'd0, ctrl_err}, 32'd0);
    check("rst_blk_addr", blk_addr, 32'd0);
    check("rst_busy", {31'd0, ctrl_busy}, 32'd1);
    sys_rst = 1'b0;

    // Initialisation phase: bus follows the initialiser, requests wait.
    for (int c = 0; c < 200; c++) begin
      @(negedge sys_clk);
      init_cs_n = c[0];
      init_mosi = ~c[0];
      if (c == 50) begin wr_req = 1'b1; wr_addr = 32'hA5A5_0001; sb.push_back('{1'b0, 32'hA5A5_0001}); end
      if (c == 51) wr_req = 1'b0;
      #1;
      check("init_wr_en", {31'd0, wr_en}, 32'd0);
      if (c % 20 == 0) begin
        check("init_cs_n", {31'd0, cs_n}, {31'd0, init_cs_n});
        check("init_mosi", {31'd0, mosi}, {31'd0, init_mosi});
      end
    end
    check("init_busy", {31'd0, ctrl_busy}, 32'd1);
    init_end = 1'b1;
    serve(1'b0, 3, 20, 1'b0);

    // Single read with a long busy phase.
    req(1'b1, 32'h0000_1000);
    serve(1'b1, 3, 600, 1'b0);
    check("rd_idle_busy", {31'd0, ctrl_busy}, 32'd0);
    check("idle_bus", {30'd0, cs_n, mosi}, 32'd3);

    // Simultaneous requests: priority alternates between rounds.
    req_pair(32'h1111_0001, 32'h2222_0001, 1'b0);
    serve(1'b0, 2, 10, 1'b0);
    serve(1'b1, 2, 10, 1'b0);
    req_pair(32'h1111_0002, 32'h2222_0002, 1'b1);
    serve(1'b1, 2, 10, 1'b0);
    serve(1'b0, 2, 10, 1'b0);

    // Duplicate write request while one is pending: first address wins.
    req(1'b1, 32'h0000_2000);
    serve(1'b1, 3, 300, 1'b1);
    serve(1'b0, 3, 20, 1'b0);
    repeat (30) @(negedge sys_clk);
    check("dup_idle_busy", {31'd0, ctrl_busy}, 32'd0);
    check("dup_sb_empty", sb.size(), 32'd0);

    // Start timeout: write engine never raises busy.
    req(1'b0, 32'h7100_0000);
    wait_strobe(1'b0, seen);
    for (int c = 2; c <= 12; c++) begin
      @(negedge sys_clk);
      if (c == 3) begin rd_req = 1'b1; rd_addr = 32'h7200_0000; sb.push_back('{1'b1, 32'h7200_0000}); end
      if (c == 4) rd_req = 1'b0;
      #1;
      check("to_no_done", {31'd0, wr_done}, 32'd0);
      if (c == 9)  check("to_err_early", {31'd0, ctrl_err}, 32'd0);
      if (c == 12) check("to_err_set", {31'd0, ctrl_err}, 32'd1);
    end
    serve(1'b1, 3, 20, 1'b0);
    check("err_sticky", {31'd0, ctrl_err}, 32'd1);

    // Reset during a read abandons it and clears pending work and the error.
    req(1'b1, 32'h0000_3000);
    wait_strobe(1'b1, seen);
    repeat (3) @(negedge sys_clk);
    rd_busy = 1'b1;
    repeat (10) @(negedge sys_clk);
    init_cs_n = 1'b0; init_mosi = 1'b0; rd_cs_n = 1'b1; rd_mosi = 1'b1;
    wr_req = 1'b1; wr_addr = 32'hDEAD_0000;
    @(negedge sys_clk);
    wr_req = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    #1;
    check("rstmid_cs_n", {30'd0, cs_n, mosi}, 32'd0);
    check("rstmid_err", {31'd0, ctrl_err}, 32'd0);
    check("rstmid_done", {31'd0, rd_done}, 32'd0);
    sys_rst = 1'b0;
    rd_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      check("rstmid_no_op", {29'd0, rd_done, wr_en, rd_en}, 32'd0);
    end
    check("rstmid_pend_clear", {31'd0, ctrl_busy}, 32'd0);

    // Operation timeout: busy never falls within OP_TO.
    req(1'b1, 32'h0000_4000);
    wait_strobe(1'b1, seen);
    repeat (3) @(negedge sys_clk);
    rd_busy = 1'b1;
    for (int i = 0; i < 720; i++) begin
      @(negedge sys_clk);
      if (i % 100 == 0) check("op_no_done", {31'd0, rd_done}, 32'd0);
      if (i == 600) check("op_err_early", {31'd0, ctrl_err}, 32'd0);
    end
    check("op_err_set", {31'd0, ctrl_err}, 32'd1);
    check("op_idle", {31'd0, ctrl_busy}, 32'd0);
    rd_busy = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      check("op_no_late_done", {31'd0, rd_done}, 32'd0);
    end
    check("final_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sd_ctrl.md
Name: sd_ctrl

Overview:
- SPI-bus controller/arbiter for the SD card interface.
- Holds the bus for the card initialiser until init_end, then shares the single cs_n/mosi/miso bus between a block-write engine and a block-read engine.
- Latches pulse requests, arbitrates with alternating priority and issues one-cycle start strobes. Tracks engine busy handshakes, enforces timeouts and flags errors.
- Sits between the UART-side command logic and the sd_init / sd_write / sd_read engines.

Parameters:
- START_TO, 16'd1000: max cycles from start strobe to engine busy rising.
- OP_TO, 24'd2_000_000: max cycles engine busy may stay high.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- init_end  in  1  initialiser done (level).
- init_cs_n  in  1  initialiser chip select.
- init_mosi  in  1  initialiser MOSI.
- wr_req  in  1  write request pulse.
- wr_addr  in  32  write block address, sampled with wr_req.
- rd_req  in  1  read request pulse.
- rd_addr  in  32  read block address, sampled with rd_req.
- wr_busy  in  1  write engine busy.
- wr_cs_n  in  1  write engine chip select.
- wr_mosi  in  1  write engine MOSI.
- rd_busy  in  1  read engine busy.
- rd_cs_n  in  1  read engine chip select.
- rd_mosi  in  1  read engine MOSI.
- cs_n  out  1  card chip select.
- mosi  out  1  card MOSI.
- wr_en  out  1  one-cycle write start strobe.
- rd_en  out  1  one-cycle read start strobe.
- blk_addr  out  32  address of the granted operation.
- wr_done  out  1  one-cycle pulse at write completion.
- rd_done  out  1  one-cycle pulse at read completion.
- ctrl_busy  out  1  high unless in S_IDLE with nothing pending.
- ctrl_err  out  1  sticky timeout flag, cleared only by sys_rst.

Behaviour:
- Reset values:
  - state = S_INIT.
  - wr_en = rd_en = wr_done = rd_done = ctrl_err = 0.
  - blk_addr = 0, ctrl_busy = 1.
  - Pending flags cleared, priority pointer = write.
  - Reset mid-operation abandons the operation; the bus returns to the initialiser on the next cycle.
- Bus mux (combinational from registered state):
  - S_INIT: cs_n = init_cs_n, mosi = init_mosi.
  - S_WR_START / S_WR: write engine signals.
  - S_RD_START / S_RD: read engine signals.
  - Otherwise: cs_n = 1, mosi = 1.
- Request latching:
  - wr_req sets wr_pend and captures wr_addr into wr_addr_q, in any state.
  - A wr_req while wr_pend is already set is ignored (first address kept).
  - The same rules apply to rd_req with rd_pend and rd_addr_q.
- States:
  - S_INIT: wait for init_end = 1, then go to S_IDLE. Requests latch but are not served.
  - S_IDLE, only wr_pend set: grant write.
  - S_IDLE, only rd_pend set: grant read.
  - S_IDLE, both set: grant the side named by the priority pointer, then point the pointer at the other side.
  - On grant: clear that pend flag, load blk_addr from the latched address, go to the *_START state.
  - S_WR_START: wr_en = 1 on the first cycle only. Wait for wr_busy = 1, then go to S_WR. If START_TO cycles elapse first, set ctrl_err and go to S_IDLE.
  - S_WR: wait for wr_busy = 0. Then pulse wr_done for one cycle and go to S_IDLE. If OP_TO cycles elapse, set ctrl_err and go to S_IDLE; no done pulse.
  - S_RD_START / S_RD: same as the write states, using rd_en, rd_busy and rd_done.
- Latency: a request arriving in idle is granted 2 cycles after the req pulse (1 cycle latch, 1 cycle grant); the strobe asserts in the first *_START cycle.
- Timeout counter: 24-bit, cleared on every state change, saturates; never wraps.
- A new request for the channel being served latches as pending and is served later; it never aborts the current operation.
- The grant of a single request never waits on the other channel.

Test Plan:
- Reset, init_end low for 200 cycles, init_cs_n toggling → cs_n follows init_cs_n. wr_req at cycle 50 is not served (wr_en stays 0). init_end high → wr_en pulses once, blk_addr = latched wr_addr.
- After init: rd_req with rd_addr = 32'h0000_1000; rd_busy high 3 cycles after rd_en for 600 cycles → cs_n/mosi follow rd_*, rd_done pulses once after rd_busy falls, ctrl_busy = 0 afterwards.
- wr_req and rd_req in the same cycle, then again after completion → order is write, read, then read, write (priority alternates). Addresses match the respective requests.
- Second wr_req with a different address while wr_pend is set → only the first address is used; exactly one write is issued.
- START_TO = 16'd10, engine never raises busy → ctrl_err = 1 at cycle 10 of S_WR_START, no wr_done. The next pending request is still served; ctrl_err stays 1.
- sys_rst asserted during S_RD → next cycle cs_n follows init_cs_n, pend flags clear, ctrl_err = 0, no rd_done.
